sram_like_responder: RTL and testbench

Memory-side responder for the core's SRAM-like bus (request/addr_ok/data_ok). Backs one instruction or data port with on-chip word-addressed RAM. Accepts pipelined requests, performs byte-strobed writes and reads, and returns in-order responses after a fixed latency. An optional pseudo-random stall mode exercises the core's handshake corners.

---
 rtl/sram_like_responder_if.sv | 22 ++
 rtl/sram_like_responder.sv | 123 ++++++++++++
 tb/tb_sram_like_responder.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_like_responder_if.sv
// SRAM-like bus bundle (request/addr_ok/data_ok) between a core port and its memory.
interface sram_like_responder_if;
    logic        req;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        addr_ok;
    logic [31:0] rdata;
    logic        data_ok;

    modport master (
        output req, wr, wstrb, addr, size, wdata,
        input  addr_ok, rdata, data_ok
    );

    modport slave (
        input  req, wr, wstrb, addr, size, wdata,
        output addr_ok, rdata, data_ok
    );
endinterface

// File: rtl/sram_like_responder.sv
// On-chip word RAM behind the SRAM-like bus. Requests are accepted while
// fewer than MAX_OUTSTANDING are unanswered, flow through a LATENCY-deep
// result pipeline and drain in order through a small response FIFO.
// An LFSR can randomly hold off addr_ok / data_ok to exercise the core.
module sram_like_responder #(
    parameter int ADDR_WIDTH      = 12,
    parameter int LATENCY         = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  i_clk,
    input  logic                  i_resetn,
    input  logic                  i_stall_en,
    sram_like_responder_if.slave  bus
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [31:0]             r_mem [2**ADDR_WIDTH];

    logic                    r_rdy;
    logic [7:0]              r_lfsr;
    logic [CW-1:0]           r_count;

    logic [LATENCY-1:0]      r_vld_pipe;
    logic [LATENCY-1:0]      r_wr_pipe;
    logic [LATENCY-1:0][31:0] r_dat_pipe;

    logic [2**PW-1:0]        r_fwr;
    logic [31:0]             r_fdat [2**PW];
    logic [PW-1:0]           r_rptr;
    logic [PW-1:0]           r_wptr;
    logic [CW-1:0]           r_fcnt;

    logic [ADDR_WIDTH-1:0]   w_idx;
    logic                    w_accept;
    logic                    w_fifo_empty;
    logic                    w_head_vld;
    logic                    w_head_wr;
    logic [31:0]             w_head_dat;
    logic                    w_respond;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_unused;

    // size and the non-index address bits carry no meaning here.
    assign w_unused = ^{bus.size, bus.addr[31:ADDR_WIDTH+2], bus.addr[1:0]};

    assign w_idx       = bus.addr[ADDR_WIDTH+1:2];
    // r_rdy keeps addr_ok low until the cycle after resetn is seen high.
    assign bus.addr_ok = r_rdy && (r_count < CW'(MAX_OUTSTANDING)) && !(i_stall_en && r_lfsr[0]);
    assign w_accept    = bus.req && bus.addr_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Response selection: FIFO head, or the pipeline output directly when the FIFO is empty.
    always_comb begin
        w_fifo_empty = (r_fcnt == '0);
        w_head_vld   = !w_fifo_empty || r_vld_pipe[LATENCY-1];
        w_head_wr    = w_fifo_empty ? r_wr_pipe[LATENCY-1]  : r_fwr[r_rptr];
        w_head_dat   = w_fifo_empty ? r_dat_pipe[LATENCY-1] : r_fdat[r_rptr];
        w_respond    = w_head_vld && !(i_stall_en && r_lfsr[1]);
        w_pop        = w_respond && !w_fifo_empty;
        w_push       = r_vld_pipe[LATENCY-1] && !(w_respond && w_fifo_empty);
    end

    assign bus.data_ok = w_respond;
    assign bus.rdata   = (w_respond && !w_head_wr) ? w_head_dat : 32'h0;

    // Byte-strobed RAM write; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (w_accept && bus.wr) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.wstrb[i]) r_mem[w_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by r_fcnt.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fwr[r_wptr]  <= r_wr_pipe[LATENCY-1];
            r_fdat[r_wptr] <= r_dat_pipe[LATENCY-1];
        end
    end

    // Control state: LFSR, outstanding count, result pipeline, FIFO pointers.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_rdy      <= 1'b0;
            r_lfsr     <= 8'h5A;
            r_count    <= '0;
            r_vld_pipe <= '0;
            r_wr_pipe  <= '0;
            r_dat_pipe <= '0;
            r_rptr     <= '0;
            r_wptr     <= '0;
            r_fcnt     <= '0;
        end else begin
            r_rdy   <= 1'b1;
            r_lfsr  <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
            r_count <= r_count + CW'(w_accept) - CW'(w_respond);
            // Old RAM word is sampled here, so a read never sees a same-cycle write.
            r_vld_pipe[0] <= w_accept;
            r_wr_pipe[0]  <= bus.wr;
            r_dat_pipe[0] <= r_mem[w_idx];
            for (int k = 1; k < LATENCY; k++) begin
                r_vld_pipe[k] <= r_vld_pipe[k-1];
                r_wr_pipe[k]  <= r_wr_pipe[k-1];
                r_dat_pipe[k] <= r_dat_pipe[k-1];
            end
            if (w_push) r_wptr <= ptr_inc(r_wptr);
            if (w_pop)  r_rptr <= ptr_inc(r_rptr);
            r_fcnt <= r_fcnt + CW'(w_push) - CW'(w_pop);
        end
    end

    // The outstanding limit must keep the FIFO from ever overflowing.
    always_ff @(posedge i_clk) begin
        if (i_resetn) assert (!(w_push && !w_pop && r_fcnt == CW'(MAX_OUTSTANDING)));
    end
endmodule

// File: tb/tb_sram_like_responder.sv
module tb_sram_like_responder;
    localparam int L  = 2;
    localparam int M  = 4;
    localparam int AW = 12;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic stall_en = 1'b0;
    logic stall1 = 1'b0;
    always #5 clk = ~clk;

    sram_like_responder_if bus();
    sram_like_responder_if bus1();

    sram_like_responder #(.ADDR_WIDTH(AW), .LATENCY(L), .MAX_OUTSTANDING(M)) u_dut (
        .i_clk(clk), .i_resetn(resetn), .i_stall_en(stall_en), .bus(bus));

    sram_like_responder #(.ADDR_WIDTH(AW), .LATENCY(2), .MAX_OUTSTANDING(1)) u_dut1 (
        .i_clk(clk), .i_resetn(resetn), .i_stall_en(stall1), .bus(bus1));

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int due; logic [31:0] d; } rsp_t;
    rsp_t        mq[$];
    logic [31:0] mm [int];
    int          mcnt = 0;
    logic [7:0]  mlfsr = 8'h5A;
    bit          mrdy = 0;
    bit          chk_en = 0;

    int          acc_log[$];
    int          rsp_cyc[$];
    logic [31:0] rsp_dat[$];

    always @(negedge clk) begin : model
        bit ea, ed, acc;
        logic [31:0] er, w;
        int idx;
        ea = mrdy && (mcnt < M) && !(stall_en && mlfsr[0]);
        ed = (mq.size() > 0) && (mq[0].due <= cyc) && !(stall_en && mlfsr[1]);
        er = ed ? mq[0].d : 32'h0;
        if (chk_en) begin
            chk("addr_ok", bus.addr_ok, ea);
            chk("data_ok", bus.data_ok, ed);
            chk("rdata", bus.rdata, er);
        end
        if (bus.req && bus.addr_ok) acc_log.push_back(cyc);
        if (bus.data_ok) begin
            rsp_cyc.push_back(cyc);
            rsp_dat.push_back(bus.rdata);
        end
        if (!resetn) begin
            mq.delete();
            mcnt = 0;
            mlfsr = 8'h5A;
            mrdy = 0;
            chk_en = 1;
        end else begin
            acc = bus.req && ea;
            if (ed) void'(mq.pop_front());
            if (acc) begin
                idx = int'(bus.addr[AW+1:2]);
                w = mm.exists(idx) ? mm[idx] : 32'h0;
                if (bus.wr) begin
                    mq.push_back('{cyc + L, 32'h0});
                    for (int b = 0; b < 4; b++)
                        if (bus.wstrb[b]) w[8*b +: 8] = bus.wdata[8*b +: 8];
                    mm[idx] = w;
                end else begin
                    mq.push_back('{cyc + L, w});
                end
            end
            mcnt = mcnt + int'(acc) - int'(ed);
            mlfsr = {mlfsr[6:0], mlfsr[7] ^ mlfsr[5] ^ mlfsr[4] ^ mlfsr[3]};
            mrdy = 1;
        end
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    // Called at posedge+1; returns at posedge+1 after the accepting edge, req still high.
    task automatic issue(input bit w, input logic [3:0] s, input logic [31:0] a,
                         input logic [31:0] d, output int waits);
        bit a_ok;
        waits = 0;
        bus.req = 1'b1; bus.wr = w; bus.wstrb = s; bus.addr = a; bus.wdata = d;
        while (1) begin
            @(negedge clk);
            a_ok = bus.addr_ok;
            @(posedge clk);
            #1;
            if (a_ok) break;
            waits++;
            if (waits > 200) begin
                n_chk++; n_fail++;
                $display("FAIL accept_timeout: got no addr_ok, want accept within 200 cycles (addr %h)", a);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        bus.req = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_next(input string nm, input logic [31:0] exp_d, input int exp_lat, output int rc);
        int a;
        logic [31:0] d;
        rc = 0;
        if (acc_log.size() == 0 || rsp_cyc.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL %s_missing: got no response, want one", nm);
        end else begin
            a = acc_log.pop_front();
            rc = rsp_cyc.pop_front();
            d = rsp_dat.pop_front();
            chk({nm, "_data"}, d, exp_d);
            if (exp_lat >= 0) chk({nm, "_lat"}, rc - a, exp_lat);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int w, tot, rc, prev, ndok, ost;
        bit pat [9];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        bus.req = 0; bus.wr = 0; bus.wstrb = 0; bus.addr = 0; bus.size = 3'd2; bus.wdata = 0;
        bus1.req = 0; bus1.wr = 0; bus1.wstrb = 0; bus1.addr = 0; bus1.size = 3'd2; bus1.wdata = 0;

        resetn = 0;
        repeat (2) @(posedge clk);
        #1 resetn = 1;
        @(negedge clk);
        chk("rst_addr_ok", bus.addr_ok, 0);
        chk("rst_data_ok", bus.data_ok, 0);
        chk("rst_rdata", bus.rdata, 0);
        @(negedge clk);
        chk("post_rst_addr_ok", bus.addr_ok, 1);
        @(posedge clk); #1;

        // full write, then read
        issue(1, 4'hF, 32'h100, 32'h11223344, w);
        issue(0, 4'h0, 32'h100, 32'h0, w);
        idle(4);
        chk_next("wr_full", 32'h0, 2, rc);
        chk_next("rd_full", 32'h11223344, 2, rc);

        // partial write lanes 0 and 2, then read
        issue(1, 4'b0101, 32'h100, 32'hAABBCCDD, w);
        issue(0, 4'h0, 32'h100, 32'h0, w);
        idle(4);
        chk_next("wr_part", 32'h0, 2, rc);
        chk_next("rd_part", 32'h11BB33DD, 2, rc);

        // aliasing: upper and low byte-offset bits ignored
        issue(0, 4'hF, 32'hABC0_4103, 32'h0, w);
        idle(4);
        chk_next("rd_alias", 32'h11BB33DD, 2, rc);

        // read-after-write ordering, back to back
        issue(1, 4'hF, 32'h200, 32'hDEADBEEF, w);
        idle(3);
        chk_next("wr_200", 32'h0, 2, rc);
        issue(1, 4'hF, 32'h200, 32'h0, w);
        issue(0, 4'h0, 32'h200, 32'h0, w);
        idle(4);
        chk_next("wr_zero", 32'h0, 2, rc);
        chk_next("raw_read", 32'h0, 2, rc);

        // zero strobe: nothing written, still answered
        issue(1, 4'h0, 32'h200, 32'hFFFFFFFF, w);
        issue(0, 4'h0, 32'h200, 32'h0, w);
        idle(4);
        chk_next("wr_nostrb", 32'h0, 2, rc);
        chk_next("rd_nostrb", 32'h0, 2, rc);

        // 10 back-to-back reads at full throughput
        for (int k = 0; k < 10; k++) issue(1, 4'hF, 32'h400 + 4*k, 32'hC0DE0000 + k, w);
        idle(4);
        for (int k = 0; k < 10; k++) chk_next("b2b_wr", 32'h0, -1, rc);
        tot = 0;
        for (int k = 0; k < 10; k++) begin
            issue(0, 4'h0, 32'h400 + 4*k, 32'h0, w);
            tot += w;
        end
        idle(5);
        chk("b2b_waits", tot, 0);
        prev = 0;
        for (int k = 0; k < 10; k++) begin
            chk_next("b2b_rd", 32'hC0DE0000 + k, 2, rc);
            if (k > 0) chk("b2b_consec", rc - prev, 1);
            prev = rc;
        end

        // MAX_OUTSTANDING=1 instance: req held high
        bus1.req = 1; bus1.wr = 1; bus1.wstrb = 4'h0; bus1.addr = 32'h40; bus1.wdata = 32'hFFFFFFFF;
        ndok = 0; ost = 0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (i < 9) chk("m1_addr_ok", bus1.addr_ok, pat[i]);
            if (bus1.data_ok) begin
                ndok++;
                chk("m1_rdata", bus1.rdata, 0);
            end
            ost = ost + int'(bus1.req && bus1.addr_ok) - int'(bus1.data_ok);
            chk("m1_outstanding_le1", (ost <= 1), 1);
            @(posedge clk); #1;
            if (i == 8) bus1.req = 0;
        end
        chk("m1_dok_count", ndok, 3);

        // reset with three requests in flight
        acc_log.delete(); rsp_cyc.delete(); rsp_dat.delete();
        issue(0, 4'h0, 32'h100, 32'h0, w);
        issue(0, 4'h0, 32'h200, 32'h0, w);
        issue(0, 4'h0, 32'h400, 32'h0, w);
        bus.req = 0;
        resetn = 0;
        @(posedge clk); #1;
        resetn = 1;
        acc_log.delete(); rsp_cyc.delete(); rsp_dat.delete();
        @(negedge clk);
        chk("mid_rst_addr_ok", bus.addr_ok, 0);
        chk("mid_rst_data_ok", bus.data_ok, 0);
        @(negedge clk);
        chk("mid_rst_addr_ok_after", bus.addr_ok, 1);
        idle(6);
        chk("mid_rst_no_rsp", rsp_cyc.size(), 0);
        // RAM survives reset
        issue(0, 4'h0, 32'h100, 32'h0, w);
        idle(4);
        chk_next("rd_after_rst", 32'h11BB33DD, 2, rc);

        // random traffic with stalls
        stall_en = 1;
        acc_log.delete(); rsp_cyc.delete(); rsp_dat.delete();
        for (int k = 0; k < 16; k++) issue(1, 4'hF, 32'(4*k), $urandom, w);
        for (int n = 0; n < 1000; n++) begin
            logic [31:0] a;
            a = $urandom;
            a[13:6] = 8'h0;
            issue(1'($urandom_range(0, 1)), 4'($urandom), a, $urandom, w);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(60);
        stall_en = 0;
        idle(4);
        chk("rand_all_answered", rsp_cyc.size(), acc_log.size());

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
